cmp_sweep_driver: RTL

Sequential initiator for the combinational comparator (`comp`). It accepts a sweep request, drives one operand pair per cycle into the comparator, and samples the comparator's `z` flag. It reports the match count and the first matching index at the end of the sweep. It sits between the control/CSR logic and the comparator instance, and replaces hand-driven `x`/`y` stimulus.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp_match_tracker.sv | 47 ++++
 rtl/cmp_sweep_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the comparator and its sweep driver:
//   CMP_N_DEF          default operand width
//   CMP_CNT_W_DEF      default sweep length / index / match counter width
//   cmp_sweep_state_t  sweep driver FSM state encoding
// ---------------------------------------------------------------------------
package cmp_pkg;

    localparam int CMP_N_DEF     = 8;
    localparam int CMP_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_sweep_state_t;

endpackage

// File: rtl/cmp_match_tracker.sv
// ---------------------------------------------------------------------------
// cmp_match_tracker
// Accumulates comparator results over one sweep.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   clear      zero all results (sweep accepted)
//   sample_en  the current element is live and must be sampled
//   z          comparator result for the current element
//   idx        index of the current element
//   match_cnt  number of sampled z=1
//   found      at least one match since the last clear
//   first_idx  index of the first match, 0 if none
// ---------------------------------------------------------------------------
module cmp_match_tracker
    import cmp_pkg::*;
#(
    parameter int CNT_W = CMP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             z,
    input  logic [CNT_W-1:0] idx,
    output logic [CNT_W-1:0] match_cnt,
    output logic             found,
    output logic [CNT_W-1:0] first_idx
);

    // match_cnt cannot wrap: it is bounded by the sweep length, itself a
    // CNT_W-bit quantity.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            match_cnt <= '0;
            found     <= 1'b0;
            first_idx <= '0;
        end else if (sample_en && z) begin
            match_cnt <= match_cnt + CNT_W'(1);
            if (!found) begin
                found     <= 1'b1;
                first_idx <= idx;
            end
        end
    end

endmodule

// File: rtl/cmp_sweep_driver.sv
// ---------------------------------------------------------------------------
// cmp_sweep_driver
// Issues one operand pair per cycle to the combinational comparator and
// collects its z flag over a sweep of `count` elements.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a sweep request, results held
//   RUN   | element idx on cmp_x/cmp_y, z sampled at end of cycle
//   DONE  | one-cycle done pulse, results valid
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   start_valid / start_ready    sweep request handshake
//   x_base, x_step, y_const      operand generation, latched on accept
//   count                        number of elements (0 legal)
//   abort                        end a running sweep, current element dropped
//   cmp_x, cmp_y, cmp_valid      comparator operands and liveness
//   cmp_z                        comparator result
//   done                         one-cycle end-of-sweep pulse
//   aborted                      last sweep ended by abort
//   match_cnt, found, first_idx  sweep results
// ---------------------------------------------------------------------------
module cmp_sweep_driver
    import cmp_pkg::*;
#(
    parameter int N     = CMP_N_DEF,
    parameter int CNT_W = CMP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [N-1:0]     x_base,
    input  logic [N-1:0]     x_step,
    input  logic [N-1:0]     y_const,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [N-1:0]     cmp_x,
    output logic [N-1:0]     cmp_y,
    output logic             cmp_valid,
    input  logic             cmp_z,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] match_cnt,
    output logic             found,
    output logic [CNT_W-1:0] first_idx
);

    cmp_sweep_state_t state_q, state_d;

    logic [N-1:0]     x_step_q;
    logic [CNT_W-1:0] rem_q;     // elements still to issue, including current
    logic [CNT_W-1:0] idx_q;
    logic             accept;
    logic             sample_en;
    logic             last;

    assign accept    = (state_q == IDLE) && start_valid;
    assign sample_en = (state_q == RUN) && !abort;
    assign last      = (rem_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        cmp_valid   = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_d = (count == '0) ? DONE : RUN;
            end
            RUN: begin
                cmp_valid = 1'b1;
                if (abort || last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are loaded only for a non-empty sweep and only advanced when
    // another element follows, so the bus keeps showing the last element
    // issued once the sweep ends (and keeps the previous sweep's last pair
    // through a zero-length sweep).
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_x    <= '0;
            cmp_y    <= '0;
            x_step_q <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            aborted  <= 1'b0;
        end else if (accept) begin
            x_step_q <= x_step;
            rem_q    <= count;
            idx_q    <= '0;
            aborted  <= 1'b0;
            if (count != '0) begin
                cmp_x <= x_base;
                cmp_y <= y_const;
            end
        end else if (state_q == RUN) begin
            if (abort) begin
                aborted <= 1'b1;
            end else begin
                rem_q <= rem_q - CNT_W'(1);
                idx_q <= idx_q + CNT_W'(1);
                if (!last) cmp_x <= cmp_x + x_step_q;
            end
        end
    end

    cmp_match_tracker #(
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .sample_en (sample_en),
        .z         (cmp_z),
        .idx       (idx_q),
        .match_cnt (match_cnt),
        .found     (found),
        .first_idx (first_idx)
    );

endmodule
